data_memory_arbiter: RTL
========================

// Module: data_memory_arbiter
// PURPOSE
//  Two-master Avalon-MM arbiter in front of the single-port CPU data memory
//  (2304 x 32-bit on-chip RAM, 12-bit word address, byte enables, 1-cycle read latency).
//  m0 is the CPU data master; m1 is the coil-driver capture/DMA master.
//  Weighted round-robin: m0 gets up to M0_WEIGHT back-to-back grants, m1 gets one.
//  Fully pipelined: one transfer per clk, readdatavalid routed back to the issuing master.
// PARAMETERS
//  ADDR_W     12    word address width, both masters and memory
//  DATA_W     32    data width; byte-enable width is DATA_W/8
//  M0_WEIGHT  4     max consecutive m0 grants while m1 is requesting (1..15)
// PORTS
//  clk               in   1        system clock
//  reset_n           in   1        synchronous active-low reset
//  m0_address        in   ADDR_W   m0 word address
//  m0_byteenable     in   DATA_W/8 m0 byte lanes
//  m0_read           in   1        m0 read request
//  m0_write          in   1        m0 write request
//  m0_writedata      in   DATA_W   m0 write data
//  m0_waitrequest    out  1        1 = m0 request not accepted this cycle
//  m0_readdata       out  DATA_W   read data to m0
//  m0_readdatavalid  out  1        m0_readdata valid this cycle
//  m0_lock           in   1        hold bus for m0 (only with DATA_MEM_ARB_LOCK_EN)
//  m1_*              --   --       same set as m0 (no m1_lock)
//  mem_address       out  ADDR_W   to memory address
//  mem_byteenable    out  DATA_W/8 to memory byteenable
//  mem_chipselect    out  1        to memory chipselect
//  mem_write         out  1        to memory write
//  mem_writedata     out  DATA_W   to memory writedata
//  mem_readdata      in   DATA_W   from memory readdata (valid 1 clk after read address)
//  mem_clken         out  1        memory clock enable; constant 1
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): cnt=0, last=m1 (so m0 wins the first tie), rdv_pipe=00.
//    Outputs in reset: both readdatavalid=0, mem_chipselect=0, both waitrequest=1.
//  - reqX = mX_read | mX_write. Read and write both high is illegal; treat it as a write.
//  - Grant is combinational from the req signals, the registered last/cnt, and reset_n:
//      * only one requester: it wins
//      * both requesting: m1 wins if cnt==M0_WEIGHT or last==m0 && cnt>=M0_WEIGHT;
//        otherwise m0 wins
//  - Winner: waitrequest=0. Its address/be/writedata/write drive mem_*; mem_chipselect=1.
//    Loser: waitrequest=1. Idle: mem_chipselect=0, mem_write=0, mem_* hold the m0 values.
//  - cnt (4b): increments on an m0 grant, saturating at M0_WEIGHT.
//    Clears to 0 on an m1 grant, or on an idle cycle with m1 not requesting.
//  - last <= winner on every grant; unchanged when idle.
//  - Read latency: an accepted read at edge N asserts mX_readdatavalid for the cycle after N.
//    mX_readdata = mem_readdata, broadcast to both masters; qualify with readdatavalid.
//  - Writes produce no response. Back-to-back mixed R/W from alternating masters is
//    legal, with no bubble.
//  - Reset mid-read: readdatavalid is forced 0 at the next edge. The response is lost;
//    masters re-issue after reset.
//  - No combinational path from mem_readdata to any waitrequest.
// CONFIGURATION
//  DATA_MEM_ARB_LOCK_EN defined: m0_lock is live. An m0 grant with m0_lock=1 sets locked.
//    While locked, m1 is never granted and cnt is frozen. locked clears at the first edge
//    where m0_lock=0. Reset clears locked. Used for CPU read-modify-write on shared flags.
//  Not defined: m0_lock port is present but ignored; no lock register; pure weighted RR.
// TESTING
//  1 reset_n=0 for 2 clk while both masters request -> waitrequests=1,
//    chipselect=0, readdatavalid=0
//  2 m0 reads addr 0x010 alone (INIT word 0xDEADBEEF) -> waitrequest=0 same clk,
//    m0_readdatavalid=1 with 0xDEADBEEF next clk
//  3 both request reads continuously, M0_WEIGHT=4 -> grant pattern m0,m0,m0,m0,m1 repeating;
//    each readdatavalid goes only to its issuer
//  4 m1 writes 0x12345678 to 0x8FF with be=4'b0011, then m0 reads 0x8FF
//    -> m0 sees lower half 0x5678 over prior upper half
//  5 m0 read accepted, reset_n=0 next clk -> no readdatavalid; post-reset m0 re-read returns data
//  6 LOCK_EN: m0_lock=1 for 10 transfers with m1 requesting -> m1 waitrequest=1 throughout;
//    m1 granted the cycle after lock drops

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Two-master weighted round-robin arbiter in front of the single-port CPU data RAM.
// m0 (CPU) receives up to M0_WEIGHT back-to-back grants while m1 (capture/DMA) waits.
// Optional macro DATA_MEM_ARB_LOCK_EN enables the m0_lock bus-hold feature.
module data_memory_arbiter #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned M0_WEIGHT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic                  m0_lock,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic                  mem_clken
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WEIGHT = CNT_W'(M0_WEIGHT);

  typedef enum logic { MST_M0 = 1'b0, MST_M1 = 1'b1 } mst_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  mst_e             last_q, last_d;
  logic [1:0]       rdv_q, rdv_d;   // bit0 = m0 read in flight, bit1 = m1
  logic             req0, req1;
  logic             gnt0, gnt1;
  logic             m1_turn;
  logic             lock_hold;

`ifdef DATA_MEM_ARB_LOCK_EN
  logic locked_q, locked_d;
  assign lock_hold = locked_q;
`else
  logic unused_lock;
  assign unused_lock = m0_lock;
  assign lock_hold   = 1'b0;
`endif

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grant decision: purely from requests and registered history, never from read data
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    m1_turn = (cnt_q == WEIGHT) || ((last_q == MST_M0) && (cnt_q >= WEIGHT));
    if (reset_n) begin
      if (lock_hold) begin
        gnt0 = req0;
      end else if (req0 && req1) begin
        gnt1 = m1_turn;
        gnt0 = !m1_turn;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Memory-side mux; when idle the m0 request fields pass through with chipselect low
  always_comb begin
    mem_address    = gnt1 ? m1_address    : m0_address;
    mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
    mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
    mem_write      = (gnt1 & m1_write) | (gnt0 & m0_write);
    mem_chipselect = gnt0 | gnt1;
  end

  assign m0_waitrequest   = !gnt0;
  assign m1_waitrequest   = !gnt1;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rdv_q[0] & reset_n;
  assign m1_readdatavalid = rdv_q[1] & reset_n;
  assign mem_clken        = 1'b1;

  // Next-state for weight counter, last winner, read-valid pipe and lock
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    // read+write together counts as a write, so it launches no read response
    rdv_d  = {gnt1 & ~m1_write, gnt0 & ~m0_write};
    if (!lock_hold) begin
      if (gnt0) begin
        cnt_d = (cnt_q >= WEIGHT) ? WEIGHT : cnt_q + CNT_W'(1);
      end else if (gnt1 || !req1) begin
        cnt_d = '0;
      end
    end
    if (gnt0) begin
      last_d = MST_M0;
    end else if (gnt1) begin
      last_d = MST_M1;
    end
`ifdef DATA_MEM_ARB_LOCK_EN
    locked_d = locked_q ? m0_lock : (gnt0 & m0_lock);
`endif
  end

  // State registers with synchronous active-low reset; last=m1 lets m0 win the first tie
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      last_q   <= MST_M1;
      rdv_q    <= '0;
`ifdef DATA_MEM_ARB_LOCK_EN
      locked_q <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      rdv_q    <= rdv_d;
`ifdef DATA_MEM_ARB_LOCK_EN
      locked_q <= locked_d;
`endif
    end
  end

endmodule
